// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Imported by imem_loader and by anything that needs to decode its state.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int ADDR_STEP      = 4;

endpackage

// File: rtl/imem_loader.sv
// Runtime program loader: packs a big-endian byte stream into 32-bit words and
// writes them into instruction memory while holding the CPU in reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_SIZE  = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] num_words,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold
);

  localparam logic [31:0] MAX_WORDS = 32'((MEM_SIZE - BASE_ADDR) / BYTES_PER_WORD);
  localparam logic [31:0] BASE      = 32'(BASE_ADDR);
  localparam logic [31:0] STEP      = 32'(ADDR_STEP);
  localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  loader_state_t state_q, state_d;
  logic [15:0]   count_q, count_d;
  logic [15:0]   word_cnt_q, word_cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  // Only the three leading bytes need storing; the fourth is taken straight off the bus.
  logic [23:0]   word_q, word_d;

  logic        byte_ready_d;
  logic        wr_en_d;
  logic [31:0] wr_addr_d;
  logic [31:0] wr_data_d;
  logic        busy_d;
  logic        done_d;
  logic        error_d;
  logic        cpu_hold_d;

  logic        accept;
  logic [31:0] packed_word;

  assign accept      = byte_valid && byte_ready;
  assign packed_word = {word_q, byte_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      word_cnt_q <= '0;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_hold   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_cnt_q <= word_cnt_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      byte_ready <= byte_ready_d;
      wr_en      <= wr_en_d;
      wr_addr    <= wr_addr_d;
      wr_data    <= wr_data_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
      cpu_hold   <= cpu_hold_d;
    end
  end

  // Every output is computed one cycle early so that it leaves a flop.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    word_cnt_d   = word_cnt_q;
    addr_d       = addr_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    byte_ready_d = byte_ready;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr;
    wr_data_d    = wr_data;
    busy_d       = busy;
    done_d       = 1'b0;
    error_d      = error;
    cpu_hold_d   = cpu_hold;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_words == 16'd0) begin
            done_d  = 1'b1;
            error_d = 1'b0;
          end else if (32'(num_words) > MAX_WORDS) begin
            error_d = 1'b1;
          end else begin
            count_d      = num_words;
            addr_d       = BASE;
            byte_cnt_d   = '0;
            word_cnt_d   = '0;
            word_d       = '0;
            error_d      = 1'b0;
            busy_d       = 1'b1;
            cpu_hold_d   = 1'b1;
            byte_ready_d = 1'b1;
            state_d      = RECV;
          end
        end
      end

      RECV: begin
        if (accept) begin
          word_d     = packed_word[23:0];
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == LAST_BYTE) begin
            byte_ready_d = 1'b0;
            wr_en_d      = 1'b1;
            wr_addr_d    = addr_q;
            wr_data_d    = packed_word;
            state_d      = WRITE;
          end
        end
      end

      WRITE: begin
        addr_d     = addr_q + STEP;
        word_cnt_d = word_cnt_q + 16'd1;
        byte_cnt_d = '0;
        if (word_cnt_q + 16'd1 == count_q) begin
          done_d     = 1'b1;
          busy_d     = 1'b0;
          cpu_hold_d = 1'b0;
          state_d    = DONE;
        end else begin
          byte_ready_d = 1'b1;
          state_d      = RECV;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed byte streams push expected writes,
// a negedge monitor pops and compares every wr_en the loader produces.
module tb_imem_loader;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] num_words;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  imem_loader #(.MEM_SIZE(256), .BASE_ADDR(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_words (num_words),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .cpu_hold  (cpu_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  wr_t exp_q[$];
  int  wr_count      = 0;
  int  done_count    = 0;
  int  cycle         = 0;
  int  last_wr_cycle = 0;
  int  prev_wr_cycle = 0;
  int  done_cycle    = 0;
  logic [31:0] last_wr_addr = '0;
  logic busy_seen = 1'b0;
  logic busy_at_done = 1'b0;
  int  wr_base   = 0;
  int  done_base = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the expected queue.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
      if (wr_en) begin
        wr_count++;
        prev_wr_cycle = last_wr_cycle;
        last_wr_cycle = cycle;
        last_wr_addr  = wr_addr;
        if (exp_q.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected none", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          check_output("wr_addr", wr_addr, e.addr);
          check_output("wr_data", wr_data, e.data);
          check_output("cpu_hold_at_write", {31'd0, cpu_hold}, 32'd1);
        end
      end
      if (done) begin
        done_count++;
        done_cycle   = cycle;
        busy_at_done = busy;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic apply_reset();
    reset      = 1'b1;
    start      = 1'b0;
    num_words  = '0;
    byte_valid = 1'b0;
    byte_data  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_all_low(input string tag);
    check_output({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
    check_output({tag, "_wr_en"},      {31'd0, wr_en},      32'd0);
    check_output({tag, "_wr_addr"},    wr_addr,             32'd0);
    check_output({tag, "_wr_data"},    wr_data,             32'd0);
    check_output({tag, "_busy"},       {31'd0, busy},       32'd0);
    check_output({tag, "_done"},       {31'd0, done},       32'd0);
    check_output({tag, "_error"},      {31'd0, error},      32'd0);
    check_output({tag, "_cpu_hold"},   {31'd0, cpu_hold},   32'd0);
  endtask

  // Called on a negedge; returns on the negedge after start was sampled.
  task automatic apply_stimulus(input logic [15:0] n);
    wr_base   = wr_count;
    done_base = done_count;
    busy_seen = 1'b0;
    start     = 1'b1;
    num_words = n;
    @(negedge clk);
    start     = 1'b0;
    num_words = 16'hFFFF;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic ok;
    ok = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 200; i++) begin
      if (byte_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    if (!ok) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL byte_accept_timeout: got no handshake, expected byte 0x%02h accepted", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8],  gap);
    send_byte(w[7:0],   gap);
  endtask

  task automatic wait_done(input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_count != done_base) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!found) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL done_timeout: got no done pulse, expected one within %0d cycles", budget);
    end
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  k;

    apply_reset();
    check_all_low("reset");

    // Two words back to back.
    exp_q.push_back('{addr: 32'h0, data: 32'h20110001});
    exp_q.push_back('{addr: 32'h4, data: 32'h20120002});
    apply_stimulus(16'd2);
    check_output("busy_after_start",       {31'd0, busy},       32'd1);
    check_output("cpu_hold_after_start",   {31'd0, cpu_hold},   32'd1);
    check_output("byte_ready_after_start", {31'd0, byte_ready}, 32'd1);
    send_word(32'h20110001, 0);
    send_word(32'h20120002, 0);
    wait_done(20);
    check_output("two_word_writes", wr_count - wr_base, 32'd2);
    check_output("cycles_per_word", last_wr_cycle - prev_wr_cycle, 32'd5);
    check_output("done_after_last_write", done_cycle - last_wr_cycle, 32'd1);
    check_output("busy_at_done", {31'd0, busy_at_done}, 32'd0);
    check_output("cpu_hold_at_done", {31'd0, cpu_hold}, 32'd0);

    // Same stream with varying valid gaps.
    @(negedge clk);
    exp_q.push_back('{addr: 32'h0, data: 32'h20110001});
    exp_q.push_back('{addr: 32'h4, data: 32'h20120002});
    apply_stimulus(16'd2);
    w = 32'h20110001;
    for (int i = 0; i < 4; i++) send_byte(w[31 - 8*i -: 8], i);
    w = 32'h20120002;
    for (int i = 0; i < 4; i++) send_byte(w[31 - 8*i -: 8], 3 - i);
    wait_done(40);
    check_output("gap_writes", wr_count - wr_base, 32'd2);
    check_output("gap_queue_empty", exp_q.size(), 32'd0);

    // Zero-length load.
    @(negedge clk);
    apply_stimulus(16'd0);
    wait_done(10);
    repeat (3) @(negedge clk);
    check_output("zero_done_pulses", done_count - done_base, 32'd1);
    check_output("zero_writes", wr_count - wr_base, 32'd0);
    check_output("zero_busy_seen", {31'd0, busy_seen}, 32'd0);
    check_output("zero_error", {31'd0, error}, 32'd0);

    // Oversized load: 65 words exceeds 256 bytes.
    apply_stimulus(16'd65);
    repeat (10) @(negedge clk);
    check_output("overflow_error", {31'd0, error}, 32'd1);
    check_output("overflow_writes", wr_count - wr_base, 32'd0);
    check_output("overflow_done", done_count - done_base, 32'd0);
    check_output("overflow_busy_seen", {31'd0, busy_seen}, 32'd0);

    // Full 64-word load.
    for (int i = 0; i < 64; i++) begin
      k = 8'(i);
      exp_q.push_back('{addr: 32'(i * 4), data: {8'hA5, k, ~k, k ^ 8'h3C}});
    end
    apply_stimulus(16'd64);
    check_output("full_error_cleared", {31'd0, error}, 32'd0);
    for (int i = 0; i < 64; i++) begin
      k = 8'(i);
      send_word({8'hA5, k, ~k, k ^ 8'h3C}, 0);
    end
    wait_done(20);
    check_output("full_writes", wr_count - wr_base, 32'd64);
    check_output("full_last_addr", last_wr_addr, 32'h000000FC);
    check_output("full_queue_empty", exp_q.size(), 32'd0);

    // Reset in the middle of a word, then a clean single-word load.
    @(negedge clk);
    apply_stimulus(16'd1);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    reset = 1'b1;
    #1;
    check_all_low("midreset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_q.push_back('{addr: 32'h0, data: 32'h02329820});
    apply_stimulus(16'd1);
    send_word(32'h02329820, 0);
    wait_done(20);
    check_output("restart_writes", wr_count - wr_base, 32'd1);
    check_output("restart_queue_empty", exp_q.size(), 32'd0);

    // A start pulse during an active load must be ignored.
    @(negedge clk);
    exp_q.push_back('{addr: 32'h0, data: 32'h11223344});
    apply_stimulus(16'd1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    start     = 1'b1;
    num_words = 16'd5;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    wait_done(20);
    repeat (20) @(negedge clk);
    check_output("ignored_start_writes", wr_count - wr_base, 32'd1);
    check_output("ignored_start_done", done_count - done_base, 32'd1);
    check_output("ignored_start_busy", {31'd0, busy}, 32'd0);
    check_output("final_queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Write-side companion to the instruction memory: accepts a byte stream over a valid/ready handshake, packs it big-endian into 32-bit instruction words, and drives a single-port write interface into instruction memory at byte addresses stepping by 4 (0, 4, 8, …), the same addressing the PC uses on the read side. While loading, it holds the CPU in reset through `cpu_hold`. It replaces hard-coded program contents with a runtime program-load path.

## Interface
- `MEM_SIZE`, 256: instruction memory entries, indexed by byte address; maximum load is `MEM_SIZE/4` words.
- `BASE_ADDR`, 0: byte address of the first word written; must be a multiple of 4.
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request to begin a load; sampled only in IDLE.
- `num_words` in 16: number of words to load; latched on accepted `start`.
- `byte_valid` in 1: `byte_data` is valid.
- `byte_data` in 8: stream byte, most significant byte of each word first.
- `byte_ready` out 1: loader accepts a byte this cycle.
- `wr_en` out 1: instruction memory write strobe, one cycle per word.
- `wr_addr` out 32: byte address of the write.
- `wr_data` out 32: instruction word to write.
- `busy` out 1: load in progress.
- `done` out 1: one-cycle pulse at the end of a load.
- `error` out 1: sticky; set on an illegal `num_words` and cleared by the next accepted `start`.
- `cpu_hold` out 1: CPU reset request, high while loading.

## Operation
- FSM states: IDLE, RECV, WRITE, DONE. All outputs are registered.
- Reset drives every output low: `byte_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `error`=0, `cpu_hold`=0. The state returns to IDLE, and all counters and the partial word are cleared.
- IDLE with `start`:
  - `num_words`=0: `done` pulses next cycle, `error` clears, state stays IDLE, no writes.
  - `num_words` > `(MEM_SIZE-BASE_ADDR)/4`: `error`=1, state stays IDLE, no writes, `done` stays low.
  - Otherwise: latch `num_words`; addr=`BASE_ADDR`, byte_cnt=0, word_cnt=0, `error`=0; set `busy`=`cpu_hold`=1; go to RECV.
- RECV:
  - `byte_ready`=1.
  - On `byte_valid`&&`byte_ready`: word = {word[23:0], `byte_data`}; byte_cnt++.
  - On the 4th accepted byte: go to WRITE, with `byte_ready` dropping the next cycle.
  - `byte_valid` low stalls the FSM indefinitely with no timeout.
- WRITE:
  - `wr_en`=1 for exactly one cycle, with `wr_addr`=addr and `wr_data`=word; `byte_ready`=0.
  - Then addr += 4, word_cnt++, byte_cnt=0.
  - If word_cnt reaches the latched count, go to DONE; otherwise go to RECV.
- DONE: `done`=1 for one cycle; `busy`=`cpu_hold`=0; go to IDLE.
- `start` outside IDLE is ignored, and `num_words` changes after latching are ignored.
- Address arithmetic is 32-bit unsigned. The overflow check guarantees no write at or beyond `MEM_SIZE`, so there is no wrap-around.
- Reset mid-operation discards the partial word immediately: no `wr_en`, no `done`, and `cpu_hold` drops asynchronously.

## Timing
- Minimum cost per word is 5 cycles: 4 byte-accept cycles plus 1 write cycle.
- `wr_en` is asserted the cycle after the 4th byte handshake.
- `done` is asserted the cycle after the final `wr_en`.
- `busy`/`cpu_hold` rise the cycle after `start` and fall the same cycle `done` rises.
- `byte_ready` rises the cycle after `start` or after a non-final write.
- No byte is accepted during WRITE; the source must hold `byte_valid`/`byte_data` stable until ready.
- `wr_addr`/`wr_data` are don't-care when `wr_en`=0. The implementation holds their last values.

## Structure
- Shared package `imem_loader_pkg`:
  - state enum `loader_state_t` (IDLE, RECV, WRITE, DONE);
  - constants `BYTES_PER_WORD`=4 and `ADDR_STEP`=4.
- Single flat module. No sub-module is needed: the byte packer is a 2-bit counter plus a shift register inside RECV.

## Test plan
- Load 2 words; bytes 20 11 00 01 20 12 00 02 back-to-back -> writes (0x0, 0x20110001) and (0x4, 0x20120002); `done` 1 cycle after the second write; `cpu_hold` high throughout.
- Same stream with `byte_valid` gaps of 0–3 cycles -> identical writes; no byte lost or duplicated; 5 cycles per word when gap-free.
- `num_words`=0 -> `done` pulse, no `wr_en`, `busy` never rises; `num_words`=65 with `MEM_SIZE`=256 -> `error`=1, no writes, `done` low.
- Full load of 64 words -> last write at 0xFC, no write at 0x100, then `done`.
- Reset asserted after 2 bytes of word 1 -> all outputs 0 at once; restart load of 1 word 0x02329820 -> single write (0x0, 0x02329820), with no stale bytes from the aborted word.
- `start` pulsed with `num_words`=5 during an active 1-word load -> ignored; exactly 1 write, then `done`.
